// File: rtl/mac_accumulator.sv
// Signed product accumulator: sums the beats of a packet, then rescales, saturates
// and holds one result on a valid/ready output with full backpressure.
module mac_accumulator #(
    parameter int unsigned IN_WIDTH    = 16,
    parameter int unsigned ACC_WIDTH   = 32,
    parameter int unsigned OUT_WIDTH   = 16,
    parameter int unsigned OUT_SCALE   = 4,
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [IN_WIDTH-1:0]    in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_overflow,
    output logic [COUNT_WIDTH-1:0]        out_count
);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    state_e                         state_q, state_d;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic [COUNT_WIDTH-1:0]         count_q, count_d;
    logic signed [OUT_WIDTH-1:0]    out_data_q, out_data_d;
    logic                           out_valid_q, out_valid_d;
    logic                           out_overflow_q, out_overflow_d;
    logic [COUNT_WIDTH-1:0]         out_count_q, out_count_d;

    logic                           accept_c;
    logic signed [ACC_WIDTH-1:0]    sum_c;
    logic signed [ACC_WIDTH-1:0]    scaled_c;
    logic [COUNT_WIDTH-1:0]         count_inc_c;

    // In HOLD the input may only advance when the pending result drains this cycle.
    assign in_ready     = (state_q == ST_ACCUM) || out_ready;
    assign accept_c     = in_valid && in_ready;

    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign out_overflow = out_overflow_q;
    assign out_count    = out_count_q;

    // acc_q is always zero in HOLD, so the same adder serves a zero-bubble restart.
    assign sum_c        = acc_q + ACC_WIDTH'(in_data);
    assign scaled_c     = sum_c >>> OUT_SCALE;
    assign count_inc_c  = (&count_q) ? count_q : count_q + COUNT_WIDTH'(1);

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        count_d        = count_q;
        out_data_d     = out_data_q;
        out_valid_d    = out_valid_q;
        out_overflow_d = out_overflow_q;
        out_count_d    = out_count_q;

        if ((state_q == ST_HOLD) && out_ready) begin
            state_d     = ST_ACCUM;
            out_valid_d = 1'b0;
        end

        if (accept_c) begin
            if (in_last) begin
                acc_d       = '0;
                count_d     = '0;
                out_count_d = count_inc_c;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
                if (scaled_c > SAT_MAX) begin
                    out_data_d     = OUT_WIDTH'(SAT_MAX);
                    out_overflow_d = 1'b1;
                end else if (scaled_c < SAT_MIN) begin
                    out_data_d     = OUT_WIDTH'(SAT_MIN);
                    out_overflow_d = 1'b1;
                end else begin
                    out_data_d     = OUT_WIDTH'(scaled_c);
                    out_overflow_d = 1'b0;
                end
            end else begin
                acc_d   = sum_c;
                count_d = count_inc_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_ACCUM;
            acc_q          <= '0;
            count_q        <= '0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            out_overflow_q <= 1'b0;
            out_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            count_q        <= count_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            out_overflow_q <= out_overflow_d;
            out_count_q    <= out_count_d;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: directed vector table, hand-written corner sequences,
// and randomized traffic against a packet-level reference model.
module tb_mac_accumulator;

    logic               clk;
    logic               rst;
    logic signed [15:0] in_data;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_overflow;
    logic [7:0]         out_count;

    int n_vec;
    int n_err;

    mac_accumulator dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_overflow(out_overflow),
        .out_count   (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int d;
        bit v;
        bit l;
        bit r;
        bit exp_ir;
        bit exp_ov;
        int exp_data;
        bit exp_ovf;
        int exp_cnt;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input bit v, input bit l, input bit r);
        in_data   = 16'(d);
        in_valid  = v;
        in_last   = l;
        out_ready = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_result(input string name, input int data, input bit ovf, input int cnt);
        chk({name, " out_valid"}, int'(out_valid), 1);
        chk({name, " out_data"}, int'(out_data), data);
        chk({name, " out_overflow"}, int'(out_overflow), int'(ovf));
        chk({name, " out_count"}, int'(out_count), cnt);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, " out_valid"}, int'(out_valid), 0);
        chk({name, " out_data"}, int'(out_data), 0);
        chk({name, " out_overflow"}, int'(out_overflow), 0);
        chk({name, " out_count"}, int'(out_count), 0);
        chk({name, " in_ready"}, int'(in_ready), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    vec_t tbl[$];

    // Reference model state: beats of the open packet and the pending result.
    longint m_sum;
    int     m_n;
    bit     m_has;
    int     m_data;
    bit     m_ovf;
    int     m_cnt;

    task automatic model_close();
        int s;
        int sc;
        s  = int'(m_sum);
        sc = s >>> 4;
        m_ovf = 1'b1;
        if (sc > 32767) m_data = 32767;
        else if (sc < -32768) m_data = -32768;
        else begin
            m_data = sc;
            m_ovf  = 1'b0;
        end
        m_cnt = (m_n > 255) ? 255 : m_n;
        m_has = 1'b1;
        m_sum = 0;
        m_n   = 0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        do_reset();
        chk_reset_vals("reset");

        //          d     v  l  r  ir ov data ovf cnt
        tbl.push_back('{100,  1, 0, 1, 1, 0, 0,  0, 0});
        tbl.push_back('{200,  1, 0, 1, 1, 0, 0,  0, 0});
        tbl.push_back('{60,   1, 1, 1, 1, 1, 22, 0, 3});
        tbl.push_back('{-16,  1, 1, 1, 1, 1, -1, 0, 1});
        tbl.push_back('{-15,  1, 1, 1, 1, 1, -1, 0, 1});
        tbl.push_back('{0,    0, 0, 1, 1, 0, 0,  0, 0});
        tbl.push_back('{50,   1, 1, 1, 1, 1, 3,  0, 1});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{99, 1, 0, 0, 0, 1, 3,  0, 1});
        tbl.push_back('{7,    1, 0, 1, 1, 0, 0,  0, 0});
        tbl.push_back('{9,    1, 1, 1, 1, 1, 1,  0, 2});
        tbl.push_back('{0,    0, 0, 1, 1, 0, 0,  0, 0});
        tbl.push_back('{160,  1, 1, 1, 1, 1, 10, 0, 1});
        tbl.push_back('{320,  1, 1, 1, 1, 1, 20, 0, 1});
        tbl.push_back('{480,  1, 1, 1, 1, 1, 30, 0, 1});
        tbl.push_back('{0,    0, 0, 1, 1, 0, 0,  0, 0});
        tbl.push_back('{1234, 0, 1, 1, 1, 0, 0,  0, 0});
        tbl.push_back('{0,    0, 0, 1, 1, 0, 0,  0, 0});

        foreach (tbl[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            drive(tbl[i].d, tbl[i].v, tbl[i].l, tbl[i].r);
            chk({nm, " in_ready"}, int'(in_ready), int'(tbl[i].exp_ir));
            tick();
            chk({nm, " out_valid"}, int'(out_valid), int'(tbl[i].exp_ov));
            if (tbl[i].exp_ov) begin
                chk({nm, " out_data"}, int'(out_data), tbl[i].exp_data);
                chk({nm, " out_overflow"}, int'(out_overflow), int'(tbl[i].exp_ovf));
                chk({nm, " out_count"}, int'(out_count), tbl[i].exp_cnt);
            end
        end

        // Positive saturation over a 20-beat packet.
        for (int i = 0; i < 20; i++) begin
            drive(32767, 1'b1, i == 19, 1'b1);
            tick();
        end
        chk_result("sat_pos", 32767, 1'b1, 20);

        // Negative saturation; the first beat also consumes the pending result.
        for (int i = 0; i < 20; i++) begin
            drive(-32768, 1'b1, i == 19, 1'b1);
            tick();
        end
        chk_result("sat_neg", -32768, 1'b1, 20);
        drive(0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("sat_neg drain", int'(out_valid), 0);

        // Reset mid-packet discards the partial sum.
        for (int i = 0; i < 3; i++) begin
            drive(1000, 1'b1, 1'b0, 1'b1);
            tick();
        end
        do_reset();
        chk_reset_vals("mid_rst");
        drive(32, 1'b1, 1'b1, 1'b1);
        tick();
        chk_result("post_rst", 2, 1'b0, 1);

        // Reset while a result is pending drops it.
        drive(0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("hold before rst", int'(out_valid), 1);
        do_reset();
        chk_reset_vals("hold_rst");

        // Randomized traffic against the packet-level model.
        m_sum = 0;
        m_n   = 0;
        m_has = 1'b0;
        m_data = 0;
        m_ovf = 1'b0;
        m_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            int d;
            bit v, l, r, exp_ir;
            case ($urandom % 4)
                0:       d = 32767;
                1:       d = -32768;
                default: d = int'($urandom_range(0, 65535)) - 32768;
            endcase
            v = ($urandom % 4) != 0;
            l = ($urandom % 7) == 0;
            r = ($urandom % 3) != 0;
            drive(d, v, l, r);
            exp_ir = !m_has || r;
            chk("rnd in_ready", int'(in_ready), int'(exp_ir));
            if (m_has && r) m_has = 1'b0;
            if (v && exp_ir) begin
                m_sum += longint'(d);
                m_n++;
                if (l) model_close();
            end
            tick();
            chk("rnd out_valid", int'(out_valid), int'(m_has));
            if (m_has) begin
                chk("rnd out_data", int'(out_data), m_data);
                chk("rnd out_overflow", int'(out_overflow), int'(m_ovf));
                chk("rnd out_count", int'(out_count), m_cnt);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
